// File: rtl/spi_shift_engine.sv
// spi_shift_engine
// ----------------
// Byte-level SPI master serializer, mode 0 (CPOL=0, CPHA=0), MSB first.
// Accepts one byte plus a speed code from the register interface, drives
// sclk/mosi, samples miso and returns the received byte with a one-cycle
// rx_valid pulse. Chip-select lives outside this block.
//
// Optional build macro: SPI_TXBUF_EN
//   When defined, a one-byte transmit holding register lets a second start
//   be queued while a byte is shifting, so that bytes run back to back.
//
// Parameters:
//   DIV_SLOW  sclk half-period in cck cycles for speed code 00 (0 acts as 1)
//   DIV_MID   sclk half-period in cck cycles for speed code 01 (0 acts as 1)
//
// Ports:
//   cck       system clock, rising edge
//   _reset    synchronous active-low reset
//   start     one-cycle transfer request, honoured only while ready=1
//   tx_data   byte to send, sampled on the accepting edge
//   speed     00=DIV_SLOW, 01=DIV_MID, 1x=half-period 1
//   ready     a start presented this cycle will be accepted
//   busy      a byte is currently shifting
//   rx_data   last received byte, held until the next completion
//   rx_valid  one-cycle pulse when rx_data has just been updated
//   sclk      SPI clock, idles low
//   mosi      SPI data out, idles high
//   miso      SPI data in

module spi_shift_engine #(
  parameter int DIV_SLOW = 8,
  parameter int DIV_MID  = 4
) (
  input  logic       cck,
  input  logic       _reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic [1:0] speed,
  output logic       ready,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  // Counter reload values are H-1; a zero divider is clamped to H=1.
  localparam int         H_SLOW      = (DIV_SLOW < 1) ? 1 : DIV_SLOW;
  localparam int         H_MID       = (DIV_MID  < 1) ? 1 : DIV_MID;
  localparam logic [7:0] RELOAD_SLOW = 8'(H_SLOW - 1);
  localparam logic [7:0] RELOAD_MID  = 8'(H_MID - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state, state_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] reload, reload_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       sclk_q, sclk_n;
  logic       mosi_q, mosi_n;
  logic [7:0] rx_data_q, rx_data_n;
  logic       rx_valid_q, rx_valid_n;
  logic [7:0] reload_sel;
  logic       load_en;
  logic [7:0] load_byte;

`ifdef SPI_TXBUF_EN
  logic [7:0] hold_data, hold_data_n;
  logic       hold_full, hold_full_n;
  logic       done;
`endif

  assign busy     = (state == SHIFT);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_TXBUF_EN
  assign ready = !hold_full;
`else
  assign ready = !busy;
`endif

  // Half-period reload chosen from the live speed input; it is only
  // captured into 'reload' when a byte is loaded, so mid-byte speed
  // changes cannot disturb the byte in flight.
  always_comb begin
    case (speed)
      2'b00:   reload_sel = RELOAD_SLOW;
      2'b01:   reload_sel = RELOAD_MID;
      default: reload_sel = 8'd0;
    endcase
  end

  always_ff @(posedge cck) begin
    if (!_reset) begin
      state      <= IDLE;
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      cnt        <= 8'h00;
      reload     <= 8'h00;
      bit_cnt    <= 3'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
`ifdef SPI_TXBUF_EN
      hold_data  <= 8'h00;
      hold_full  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      tx_shift   <= tx_shift_n;
      rx_shift   <= rx_shift_n;
      cnt        <= cnt_n;
      reload     <= reload_n;
      bit_cnt    <= bit_cnt_n;
      sclk_q     <= sclk_n;
      mosi_q     <= mosi_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
`ifdef SPI_TXBUF_EN
      hold_data  <= hold_data_n;
      hold_full  <= hold_full_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    cnt_n      = cnt;
    reload_n   = reload;
    bit_cnt_n  = bit_cnt;
    sclk_n     = sclk_q;
    mosi_n     = mosi_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    load_en    = 1'b0;
    load_byte  = tx_data;
`ifdef SPI_TXBUF_EN
    hold_data_n = hold_data;
    hold_full_n = hold_full;
    done        = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (start && ready) begin
          load_en = 1'b1;
        end
      end

      SHIFT: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          cnt_n  = reload;
          sclk_n = !sclk_q;
          if (!sclk_q) begin
            // Rising sclk: capture miso on the same edge.
            rx_shift_n = {rx_shift[6:0], miso};
          end else if (bit_cnt != 3'd7) begin
            // Falling sclk mid-byte: present the next transmit bit.
            tx_shift_n = {tx_shift[6:0], 1'b0};
            mosi_n     = tx_shift[6];
            bit_cnt_n  = bit_cnt + 3'd1;
          end else begin
            // Falling sclk after bit 7: the byte is complete.
            rx_data_n  = rx_shift;
            rx_valid_n = 1'b1;
            mosi_n     = 1'b1;
            state_n    = IDLE;
`ifdef SPI_TXBUF_EN
            done = 1'b1;
            // Chain straight into the next byte so no idle gap appears.
            if (hold_full) begin
              load_en     = 1'b1;
              load_byte   = hold_data;
              hold_full_n = 1'b0;
            end else if (start) begin
              load_en = 1'b1;
            end
`endif
          end
        end
`ifdef SPI_TXBUF_EN
        // A start during a byte (other than on its completion edge)
        // is parked in the holding register.
        if (start && ready && !done) begin
          hold_data_n = tx_data;
          hold_full_n = 1'b1;
        end
`endif
      end

      default: state_n = IDLE;
    endcase

    // Common byte-load path for a fresh start or a chained byte.
    if (load_en) begin
      state_n    = SHIFT;
      tx_shift_n = load_byte;
      mosi_n     = load_byte[7];
      reload_n   = reload_sel;
      cnt_n      = reload_sel;
      bit_cnt_n  = 3'd0;
      sclk_n     = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine
// -------------------
// Directed self-checking bench for spi_shift_engine. Build with
// SPI_TXBUF_EN defined to exercise the transmit holding register.

module tb_spi_shift_engine;

  logic       cck;
  logic       _reset;
  logic       start;
  logic [7:0] tx_data;
  logic [1:0] speed;
  logic       ready;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sclk;
  logic       mosi;
  logic       miso;

  int tests_run;
  int tests_failed;

  // Observations collected by drive_byte for the calling test.
  int         obs_busy;
  int         obs_pulses;
  int         obs_rises;
  logic [7:0] obs_rx;
  logic [7:0] obs_mosi;
  int         obs_hi_min, obs_hi_max, obs_lo_min, obs_lo_max;

  spi_shift_engine #(
    .DIV_SLOW (8),
    .DIV_MID  (4)
  ) dut (
    .cck      (cck),
    ._reset   (_reset),
    .start    (start),
    .tx_data  (tx_data),
    .speed    (speed),
    .ready    (ready),
    .busy     (busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  initial cck = 1'b0;
  always #5 cck = ~cck;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge cck);
    #1;
  endtask

  // Starts one byte and follows it to completion, replaying pat on miso
  // MSB-first (advancing after each falling sclk). At sample inj_cycle the
  // start/tx_data/speed inputs are overwritten with the inj_* values.
  task automatic drive_byte(input logic [7:0] tx, input logic [1:0] spd,
                            input logic [7:0] pat, input int inj_cycle,
                            input logic inj_start, input logic [7:0] inj_data,
                            input logic [1:0] inj_speed);
    int   miso_idx;
    int   run;
    logic prev;
    logic finished;
    obs_busy = 0; obs_pulses = 0; obs_rises = 0; obs_rx = 8'h00; obs_mosi = 8'h00;
    obs_hi_min = 9999; obs_hi_max = 0; obs_lo_min = 9999; obs_lo_max = 0;
    miso_idx = 7;
    miso     = pat[7];
    speed    = spd;
    tx_data  = tx;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    prev     = 1'b0;
    run      = 0;
    finished = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (c > 0) begin
        tick();
        start = 1'b0;
      end
      if (busy) obs_busy++;
      if (rx_valid) begin
        obs_pulses++;
        obs_rx = rx_data;
      end
      if (sclk !== prev) begin
        if (prev) begin
          if (run < obs_hi_min) obs_hi_min = run;
          if (run > obs_hi_max) obs_hi_max = run;
        end else begin
          if (run < obs_lo_min) obs_lo_min = run;
          if (run > obs_lo_max) obs_lo_max = run;
        end
        run = 1;
        if (sclk) begin
          obs_mosi = {obs_mosi[6:0], mosi};
          obs_rises++;
        end else if (miso_idx > 0) begin
          miso_idx--;
          miso = pat[miso_idx];
        end
      end else begin
        run++;
      end
      prev = sclk;
      if (!busy) finished = 1'b1;
      if (c == inj_cycle) begin
        start   = inj_start;
        tx_data = inj_data;
        speed   = inj_speed;
      end
    end
    start = 1'b0;
    if (!finished) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL byte_timeout: busy still %0b after 400 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset;
    _reset = 1'b0;
    start = 1'b0; tx_data = 8'h00; speed = 2'b00; miso = 1'b0;
    tick(); tick();
    tests_run++; if (sclk !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sclk: got %b required 0", sclk); end
    tests_run++; if (mosi !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_mosi: got %b required 1", mosi); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rx_valid: got %b required 0", rx_valid); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rx_data: got %h required 00", rx_data); end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b required 1", ready); end
    _reset = 1'b1;
    tick();
  endtask

  task automatic test_turbo_byte;
    drive_byte(8'hA5, 2'b10, 8'h3C, -1, 1'b0, 8'h00, 2'b10);
    tests_run++; if (obs_mosi !== 8'hA5) begin tests_failed++; $display("[TB] FAIL turbo_mosi: got %h required a5", obs_mosi); end
    tests_run++; if (obs_rises !== 8) begin tests_failed++; $display("[TB] FAIL turbo_rises: got %0d required 8", obs_rises); end
    tests_run++; if (obs_rx !== 8'h3C) begin tests_failed++; $display("[TB] FAIL turbo_rx: got %h required 3c", obs_rx); end
    tests_run++; if (obs_pulses !== 1) begin tests_failed++; $display("[TB] FAIL turbo_pulses: got %0d required 1", obs_pulses); end
    tests_run++; if (obs_busy !== 16) begin tests_failed++; $display("[TB] FAIL turbo_busy_cycles: got %0d required 16", obs_busy); end
    tick();
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL turbo_pulse_width: got %b required 0", rx_valid); end
    tests_run++; if (rx_data !== 8'h3C) begin tests_failed++; $display("[TB] FAIL turbo_rx_hold: got %h required 3c", rx_data); end
  endtask

  task automatic test_slow_byte;
    tests_run++; if (mosi !== 1'b1) begin tests_failed++; $display("[TB] FAIL slow_mosi_before: got %b required 1", mosi); end
    drive_byte(8'h12, 2'b00, 8'h96, -1, 1'b0, 8'h00, 2'b00);
    tests_run++; if (obs_busy !== 128) begin tests_failed++; $display("[TB] FAIL slow_busy_cycles: got %0d required 128", obs_busy); end
    tests_run++; if (obs_hi_min !== 8 || obs_hi_max !== 8) begin tests_failed++; $display("[TB] FAIL slow_high_phase: got %0d..%0d required 8", obs_hi_min, obs_hi_max); end
    tests_run++; if (obs_lo_min !== 8 || obs_lo_max !== 8) begin tests_failed++; $display("[TB] FAIL slow_low_phase: got %0d..%0d required 8", obs_lo_min, obs_lo_max); end
    tests_run++; if (obs_mosi !== 8'h12) begin tests_failed++; $display("[TB] FAIL slow_mosi: got %h required 12", obs_mosi); end
    tests_run++; if (obs_rx !== 8'h96) begin tests_failed++; $display("[TB] FAIL slow_rx: got %h required 96", obs_rx); end
    tests_run++; if (mosi !== 1'b1) begin tests_failed++; $display("[TB] FAIL slow_mosi_after: got %b required 1", mosi); end
  endtask

  task automatic test_unbuffered_ignore;
    int extra_pulses;
    int extra_busy;
    drive_byte(8'hC3, 2'b10, 8'h5A, 4, 1'b1, 8'h55, 2'b10);
    extra_pulses = 0;
    extra_busy   = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rx_valid) extra_pulses++;
      if (busy) extra_busy++;
    end
    tests_run++; if (obs_mosi !== 8'hC3) begin tests_failed++; $display("[TB] FAIL ignore_mosi: got %h required c3", obs_mosi); end
    tests_run++; if (obs_busy !== 16) begin tests_failed++; $display("[TB] FAIL ignore_busy_cycles: got %0d required 16", obs_busy); end
    tests_run++; if (obs_pulses + extra_pulses !== 1) begin tests_failed++; $display("[TB] FAIL ignore_pulses: got %0d required 1", obs_pulses + extra_pulses); end
    tests_run++; if (extra_busy !== 0) begin tests_failed++; $display("[TB] FAIL ignore_no_second_byte: got %0d busy cycles required 0", extra_busy); end
    tests_run++; if (rx_data !== 8'h5A) begin tests_failed++; $display("[TB] FAIL ignore_rx: got %h required 5a", rx_data); end
  endtask

  task automatic test_speed_change;
    drive_byte(8'h81, 2'b10, 8'h00, 5, 1'b0, 8'h81, 2'b00);
    tests_run++; if (obs_busy !== 16) begin tests_failed++; $display("[TB] FAIL speedchg_first_busy: got %0d required 16", obs_busy); end
    tests_run++; if (obs_rx !== 8'h00) begin tests_failed++; $display("[TB] FAIL speedchg_first_rx: got %h required 00", obs_rx); end
    tick();
    drive_byte(8'h7E, 2'b00, 8'hFF, -1, 1'b0, 8'h00, 2'b00);
    tests_run++; if (obs_busy !== 128) begin tests_failed++; $display("[TB] FAIL speedchg_second_busy: got %0d required 128", obs_busy); end
    tests_run++; if (obs_mosi !== 8'h7E) begin tests_failed++; $display("[TB] FAIL speedchg_second_mosi: got %h required 7e", obs_mosi); end
  endtask

  task automatic test_reset_mid_byte;
    int stray;
    speed   = 2'b10;
    tx_data = 8'hA5;
    miso    = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    // Four falling edges (bit count 4) happen by the eighth edge after accept.
    for (int i = 0; i < 8; i++) tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_in_flight: got %b required 1", busy); end
    _reset = 1'b0;
    tick();
    tests_run++; if (sclk !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_sclk: got %b required 0", sclk); end
    tests_run++; if (mosi !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_mosi: got %b required 1", mosi); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_busy: got %b required 0", busy); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_rx_valid: got %b required 0", rx_valid); end
    _reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rx_valid || busy) stray++;
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("[TB] FAIL midreset_stray_activity: got %0d required 0", stray); end
    drive_byte(8'h3C, 2'b10, 8'hC3, -1, 1'b0, 8'h00, 2'b10);
    tests_run++; if (obs_rx !== 8'hC3) begin tests_failed++; $display("[TB] FAIL midreset_after_rx: got %h required c3", obs_rx); end
    tests_run++; if (obs_mosi !== 8'h3C) begin tests_failed++; $display("[TB] FAIL midreset_after_mosi: got %h required 3c", obs_mosi); end
    tests_run++; if (obs_busy !== 16) begin tests_failed++; $display("[TB] FAIL midreset_after_busy: got %0d required 16", obs_busy); end
  endtask

`ifdef SPI_TXBUF_EN
  task automatic test_back_to_back;
    int          busy_cnt;
    int          pulses;
    int          first_pulse;
    int          second_pulse;
    logic [15:0] bits;
    logic        prev;
    logic        finished;
    speed   = 2'b10;
    miso    = 1'b1;
    tx_data = 8'h12;
    start   = 1'b1;
    tick();
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL buf_ready_first: got %b required 1", ready); end
    busy_cnt = busy ? 1 : 0;
    prev     = sclk;
    tx_data  = 8'h34;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL buf_ready_drop: got %b required 0", ready); end
    pulses = 0; first_pulse = -1; second_pulse = -1; bits = 16'h0000; finished = 1'b0;
    for (int s = 1; s < 200 && !finished; s++) begin
      if (s > 1) tick();
      if (busy) busy_cnt++;
      if (rx_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = s;
        else second_pulse = s;
      end
      if (sclk && !prev) bits = {bits[14:0], mosi};
      prev = sclk;
      if (!busy) finished = 1'b1;
    end
    tests_run++; if (!finished) begin tests_failed++; $display("[TB] FAIL buf_timeout: busy %b required 0", busy); end
    tests_run++; if (pulses !== 2) begin tests_failed++; $display("[TB] FAIL buf_pulses: got %0d required 2", pulses); end
    tests_run++; if (second_pulse - first_pulse !== 16) begin tests_failed++; $display("[TB] FAIL buf_pulse_gap: got %0d required 16", second_pulse - first_pulse); end
    tests_run++; if (busy_cnt !== 32) begin tests_failed++; $display("[TB] FAIL buf_busy_cycles: got %0d required 32", busy_cnt); end
    tests_run++; if (bits !== 16'h1234) begin tests_failed++; $display("[TB] FAIL buf_mosi: got %h required 1234", bits); end
    tests_run++; if (rx_data !== 8'hFF) begin tests_failed++; $display("[TB] FAIL buf_rx: got %h required ff", rx_data); end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL buf_ready_end: got %b required 1", ready); end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_turbo_byte();
    tick();
    test_slow_byte();
    tick();
`ifdef SPI_TXBUF_EN
    test_back_to_back();
`else
    test_unbuffered_ignore();
`endif
    tick();
    test_speed_change();
    tick();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
